packet_receive: RTL and testbench

//  Receiving end of the 38-bit packet link: accepts packets from a packet-fetch source over a SEND/ACK 4-phase handshake.

---
 rtl/packet_pkg.sv | 27 ++
 rtl/packet_fifo.sv | 50 +++++
 rtl/packet_receive.sv | 100 ++++++++++
 tb/tb_packet_receive.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_pkg.sv
// Shared definitions for the 38-bit packet link receiver: bus layout, tag/destination
// constants and FSM state encoding.
package packet_pkg;

    localparam int PKT_W    = 38;
    localparam int TAG_LSB  = 35;
    localparam int GEN_LSB  = 27;
    localparam int DEST_LSB = 20;
    localparam int F_LSB    = 16;
    localparam int DATA_LSB = 0;

    localparam logic [2:0] TAG_VALID  = 3'b111;
    localparam logic [6:0] DEST_BCAST = 7'h7F;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_ACK     = 2'd2;

    function automatic logic [2:0] pkt_tag(input logic [PKT_W-1:0] p);
        return p[TAG_LSB +: 3];
    endfunction

    function automatic logic [6:0] pkt_dest(input logic [PKT_W-1:0] p);
        return p[DEST_LSB +: 7];
    endfunction

endpackage

// File: rtl/packet_fifo.sv
// First-word-fall-through FIFO holding accepted packets; head is visible on rd_data
// while non-empty and forced to zero when empty.
module packet_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 38
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/packet_receive.sv
// Receiving end of the packet link: synchronises SEND_IN, runs the 4-phase SEND/ACK
// handshake, classifies each captured packet and buffers accepted ones in a FWFT FIFO.
module packet_receive
    import packet_pkg::*;
#(
    parameter int         DEPTH       = 8,
    parameter logic [6:0] NODE_ID     = 7'd0,
    parameter logic       FILTER_EN   = 1'b0,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SEND_IN,
    input  logic [PKT_W-1:0] PACKET_IN,
    output logic             ACK_OUT,
    input  logic             RD_EN,
    output logic [PKT_W-1:0] PKT_OUT,
    output logic             PKT_VALID,
    output logic             FULL,
    output logic [15:0]      RX_CNT,
    output logic [7:0]       ERR_CNT,
    output logic [1:0]       STATE_DBG
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_req;
    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic [PKT_W-1:0]       pkt_q;
    logic                   ack_q;
    logic [15:0]            rx_cnt_q;
    logic [7:0]             err_cnt_q;
    logic                   tag_ok;
    logic                   dest_ok;
    logic                   accept;
    logic                   reject;
    logic                   fifo_full;
    logic                   fifo_empty;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], SEND_IN};
    end

    assign s_req = sync_q[SYNC_STAGES-1];

    // FULL is only consulted in IDLE; nothing else writes the FIFO, so CAPTURE always has room.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (s_req && !fifo_full) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_ACK;
            ST_ACK:     if (!s_req) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign tag_ok  = (pkt_tag(pkt_q) == TAG_VALID);
    assign dest_ok = !FILTER_EN || (pkt_dest(pkt_q) == NODE_ID) || (pkt_dest(pkt_q) == DEST_BCAST);
    assign accept  = (state_q == ST_CAPTURE) && tag_ok && dest_ok;
    assign reject  = (state_q == ST_CAPTURE) && !(tag_ok && dest_ok);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            pkt_q     <= '0;
            ack_q     <= 1'b0;
            rx_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= (state_d == ST_ACK);
            if (state_q == ST_IDLE && state_d == ST_CAPTURE) pkt_q <= PACKET_IN;
            if (accept) rx_cnt_q <= rx_cnt_q + 16'd1;
            if (reject && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    packet_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PKT_W)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .wr_en   (accept),
        .wr_data (pkt_q),
        .rd_en   (RD_EN),
        .rd_data (PKT_OUT),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign ACK_OUT   = ack_q;
    assign PKT_VALID = !fifo_empty;
    assign FULL      = fifo_full;
    assign RX_CNT    = rx_cnt_q;
    assign ERR_CNT   = err_cnt_q;
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_packet_receive.sv
// Directed bench for packet_receive: vector table plus handshake/FIFO/reset sequences.
module tb_packet_receive;
    import packet_pkg::*;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             SEND_IN = 1'b0;
    logic [PKT_W-1:0] PACKET_IN = '0;
    logic             RD_EN = 1'b0;
    logic             RD_EN_F = 1'b0;

    logic             ACK_OUT, PKT_VALID, FULL;
    logic [PKT_W-1:0] PKT_OUT;
    logic [15:0]      RX_CNT;
    logic [7:0]       ERR_CNT;
    logic [1:0]       STATE_DBG;

    logic             ack_f, valid_f, full_f;
    logic [PKT_W-1:0] pkt_out_f;
    logic [15:0]      rx_cnt_f;
    logic [7:0]       err_cnt_f;
    logic [1:0]       state_f;

    int tests  = 0;
    int errors = 0;

    logic [PKT_W-1:0] exp_q[$];
    logic [15:0]      exp_rx;
    logic [7:0]       exp_err;

    typedef struct {
        logic [2:0]  tag;
        logic [6:0]  dest;
        logic [15:0] data;
        logic        acc;
    } vec_t;

    vec_t vecs[6];

    packet_receive #(.DEPTH(8), .NODE_ID(7'd0), .FILTER_EN(1'b0), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RST(RST), .SEND_IN(SEND_IN), .PACKET_IN(PACKET_IN), .ACK_OUT(ACK_OUT),
        .RD_EN(RD_EN), .PKT_OUT(PKT_OUT), .PKT_VALID(PKT_VALID), .FULL(FULL),
        .RX_CNT(RX_CNT), .ERR_CNT(ERR_CNT), .STATE_DBG(STATE_DBG)
    );

    packet_receive #(.DEPTH(8), .NODE_ID(7'd1), .FILTER_EN(1'b1), .SYNC_STAGES(2)) dut_f (
        .CLK(CLK), .RST(RST), .SEND_IN(SEND_IN), .PACKET_IN(PACKET_IN), .ACK_OUT(ack_f),
        .RD_EN(RD_EN_F), .PKT_OUT(pkt_out_f), .PKT_VALID(valid_f), .FULL(full_f),
        .RX_CNT(rx_cnt_f), .ERR_CNT(err_cnt_f), .STATE_DBG(state_f)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    function automatic logic [PKT_W-1:0] mk(input logic [2:0] tag, input logic [7:0] gen,
                                            input logic [6:0] dest, input logic [3:0] f,
                                            input logic [15:0] data);
        return {tag, gen, dest, f, data};
    endfunction

    task automatic check(input string name, input logic [PKT_W-1:0] got, input logic [PKT_W-1:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        exp_q.delete();
        exp_rx  = '0;
        exp_err = '0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    // driver tasks
    task automatic raise(input logic [PKT_W-1:0] p);
        PACKET_IN = p;
        SEND_IN   = 1'b1;
    endtask

    task automatic wait_ack(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge CLK);
            #1;
            if (ACK_OUT) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic drop();
        bit low;
        low = 1'b0;
        SEND_IN = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            if (!ACK_OUT) begin
                low = 1'b1;
                break;
            end
        end
        check("ack_release", low, 1'b1);
    endtask

    task automatic send(input string name, input logic [PKT_W-1:0] p, input logic acc);
        int cyc;
        raise(p);
        wait_ack(20, cyc);
        check(name, (cyc > 0), 1'b1);
        if (acc) begin
            exp_q.push_back(p);
            exp_rx = exp_rx + 16'd1;
        end else if (exp_err != 8'hFF) begin
            exp_err = exp_err + 8'd1;
        end
        drop();
    endtask

    // scoreboard pop: compare head, then pulse RD_EN for one edge
    task automatic pop_check(input string name);
        logic [PKT_W-1:0] e;
        if (exp_q.size() == 0) begin
            tests++;
            errors++;
            $display("FAIL %s: scoreboard empty, nothing expected", name);
        end else begin
            e = exp_q.pop_front();
            check({name, "_valid"}, PKT_VALID, 1'b1);
            check(name, PKT_OUT, e);
        end
        RD_EN = 1'b1;
        @(posedge CLK);
        #1;
        RD_EN = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [PKT_W-1:0] p;

        vecs[0] = '{3'b111, 7'd7,  16'h1234, 1'b1};
        vecs[1] = '{3'b000, 7'd7,  16'h5555, 1'b0};
        vecs[2] = '{3'b111, 7'h7F, 16'hAAAA, 1'b1};
        vecs[3] = '{3'b011, 7'd0,  16'h0001, 1'b0};
        vecs[4] = '{3'b111, 7'd0,  16'hFFFF, 1'b1};
        vecs[5] = '{3'b110, 7'd5,  16'h0F0F, 1'b0};

        // reset state
        do_reset();
        check("rst_ack", ACK_OUT, 1'b0);
        check("rst_valid", PKT_VALID, 1'b0);
        check("rst_full", FULL, 1'b0);
        check("rst_pkt_out", PKT_OUT, '0);
        check("rst_rx", RX_CNT, '0);
        check("rst_err", ERR_CNT, '0);
        check("rst_state", STATE_DBG, ST_IDLE);

        // single packet with latency measurement
        p = mk(3'b111, 8'd0, 7'd7, 4'd1, 16'd1);
        raise(p);
        wait_ack(20, cyc);
        check("ack_latency", cyc, 4);
        check("t1_valid", PKT_VALID, 1'b1);
        check("t1_pkt", PKT_OUT, p);
        check("t1_rx", RX_CNT, 16'd1);
        drop();
        exp_rx = 16'd1;
        RD_EN = 1'b1;
        @(posedge CLK);
        #1;
        RD_EN = 1'b0;
        check("t1_empty", PKT_VALID, 1'b0);

        // vector table
        for (int i = 0; i < 6; i++) begin
            p = mk(vecs[i].tag, 8'(i), vecs[i].dest, 4'(i), vecs[i].data);
            send($sformatf("vec%0d_ack", i), p, vecs[i].acc);
            check($sformatf("vec%0d_valid", i), PKT_VALID, vecs[i].acc);
            check($sformatf("vec%0d_rx", i), RX_CNT, exp_rx);
            check($sformatf("vec%0d_err", i), ERR_CNT, exp_err);
            if (vecs[i].acc) pop_check($sformatf("vec%0d_pop", i));
        end

        // fill to full, backpressure, then release by one pop
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send("fill_ack", mk(3'b111, 8'd0, 7'd3, 4'd0, 16'(i)), 1'b1);
        end
        check("full_after_8", FULL, 1'b1);
        p = mk(3'b111, 8'd0, 7'd3, 4'd0, 16'd8);
        raise(p);
        wait_ack(30, cyc);
        check("no_ack_when_full", (cyc < 0), 1'b1);
        check("rx_while_blocked", RX_CNT, 16'd8);
        pop_check("bp_pop0");
        wait_ack(20, cyc);
        check("ack_after_pop", (cyc > 0), 1'b1);
        exp_q.push_back(p);
        exp_rx = exp_rx + 16'd1;
        drop();
        check("full_again", FULL, 1'b1);
        for (int i = 1; i <= 8; i++) pop_check($sformatf("bp_pop%0d", i));
        check("bp_drained", PKT_VALID, 1'b0);
        check("bp_rx", RX_CNT, 16'd9);

        // simultaneous write and pop during CAPTURE keeps occupancy
        do_reset();
        for (int i = 0; i < 7; i++) begin
            send("sim_fill", mk(3'b111, 8'd1, 7'd2, 4'd0, 16'(16'h100 + i)), 1'b1);
        end
        p = mk(3'b111, 8'd1, 7'd2, 4'd0, 16'h107);
        raise(p);
        cyc = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #1;
            if (STATE_DBG == ST_CAPTURE) begin
                cyc = i;
                break;
            end
        end
        check("reach_capture", (cyc >= 0), 1'b1);
        exp_q.push_back(p);
        exp_rx = exp_rx + 16'd1;
        pop_check("sim_pop0");
        wait_ack(20, cyc);
        check("sim_ack", (cyc > 0), 1'b1);
        drop();
        check("sim_not_full", FULL, 1'b0);
        send("sim_last", mk(3'b111, 8'd1, 7'd2, 4'd0, 16'h108), 1'b1);
        check("sim_full", FULL, 1'b1);
        for (int i = 1; i <= 8; i++) pop_check($sformatf("sim_pop%0d", i));
        RD_EN = 1'b1;
        @(posedge CLK);
        #1;
        RD_EN = 1'b0;
        check("empty_rd_valid", PKT_VALID, 1'b0);
        check("empty_rd_full", FULL, 1'b0);
        check("empty_rd_out", PKT_OUT, '0);
        check("sim_rx", RX_CNT, 16'd9);

        // ERR_CNT saturation
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send("sat_ack", mk(3'b101, 8'd0, 7'd0, 4'd0, 16'(i)), 1'b0);
            if (i == 254) check("err_255", ERR_CNT, 8'hFF);
        end
        check("err_sat", ERR_CNT, 8'hFF);
        check("sat_rx", RX_CNT, 16'd0);
        check("sat_valid", PKT_VALID, 1'b0);

        // reset mid-handshake, request still high afterwards
        do_reset();
        raise(mk(3'b111, 8'd2, 7'd4, 4'd0, 16'hBEEF));
        wait_ack(20, cyc);
        check("pre_rst_ack", ACK_OUT, 1'b1);
        check("pre_rst_valid", PKT_VALID, 1'b1);
        RST = 1'b1;
        #1;
        check("midrst_ack", ACK_OUT, 1'b0);
        check("midrst_valid", PKT_VALID, 1'b0);
        check("midrst_rx", RX_CNT, 16'd0);
        check("midrst_err", ERR_CNT, 8'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        wait_ack(20, cyc);
        check("post_rst_ack", (cyc > 0), 1'b1);
        check("post_rst_valid", PKT_VALID, 1'b1);
        check("post_rst_pkt", PKT_OUT, mk(3'b111, 8'd2, 7'd4, 4'd0, 16'hBEEF));
        check("post_rst_rx", RX_CNT, 16'd1);
        drop();

        // destination filter on the NODE_ID=1 instance
        do_reset();
        send("flt_own", mk(3'b111, 8'd0, 7'd1, 4'd0, 16'h0011), 1'b1);
        send("flt_bcast", mk(3'b111, 8'd0, 7'h7F, 4'd0, 16'h0022), 1'b1);
        send("flt_other", mk(3'b111, 8'd0, 7'd7, 4'd0, 16'h0033), 1'b1);
        check("flt_rx", rx_cnt_f, 16'd2);
        check("flt_err", err_cnt_f, 8'd1);
        check("flt_head", pkt_out_f, mk(3'b111, 8'd0, 7'd1, 4'd0, 16'h0011));
        RD_EN_F = 1'b1;
        @(posedge CLK);
        #1;
        RD_EN_F = 1'b0;
        check("flt_head2", pkt_out_f, mk(3'b111, 8'd0, 7'h7F, 4'd0, 16'h0022));
        RD_EN_F = 1'b1;
        @(posedge CLK);
        #1;
        RD_EN_F = 1'b0;
        check("flt_empty", valid_f, 1'b0);
        check("nofilter_rx", RX_CNT, 16'd3);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
